// File: rtl/spi_master.sv
// SPI master: shifts a WORD_W-bit frame out on sdo (MSB first) while capturing sdi.
// Data changes on sck falling edges and is sampled on sck rising edges.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] tx_data,
  output logic              ready,
  output logic              done,
  output logic [WORD_W-1:0] rx_data,
  output logic              sck,
  output logic              sdo,
  input  logic              sdi,
  output logic              cs_n
);

  localparam int               BIT_W    = $clog2(WORD_W);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, TRAIL} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [WORD_W-1:0] tx_shreg_reg, tx_shreg_next;
  logic [WORD_W-1:0] rx_shreg_reg, rx_shreg_next;
  logic [WORD_W-1:0] rx_data_reg, rx_data_next;
  logic              sck_reg, sck_next;
  logic              cs_n_reg, cs_n_next;
  logic              ready_reg, ready_next;
  logic              done_reg, done_next;
  logic              tick;
  logic              accept;

  assign tick   = (state_reg != IDLE) && (div_cnt_reg == DIV_LAST);
  assign accept = (state_reg == IDLE) && start && ready_reg;

  // sdo is the transmit register's MSB; the register is cleared at frame end so sdo idles low.
  assign sdo     = tx_shreg_reg[WORD_W-1];
  assign sck     = sck_reg;
  assign cs_n    = cs_n_reg;
  assign ready   = ready_reg;
  assign done    = done_reg;
  assign rx_data = rx_data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      tx_shreg_reg <= '0;
      rx_shreg_reg <= '0;
      rx_data_reg  <= '0;
      sck_reg      <= 1'b0;
      cs_n_reg     <= 1'b1;
      ready_reg    <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      tx_shreg_reg <= tx_shreg_next;
      rx_shreg_reg <= rx_shreg_next;
      rx_data_reg  <= rx_data_next;
      sck_reg      <= sck_next;
      cs_n_reg     <= cs_n_next;
      ready_reg    <= ready_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_cnt_next  = div_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    tx_shreg_next = tx_shreg_reg;
    rx_shreg_next = rx_shreg_reg;
    rx_data_next  = rx_data_reg;
    sck_next      = sck_reg;
    cs_n_next     = cs_n_reg;
    ready_next    = ready_reg;
    done_next     = 1'b0;

    // Half-period divider only runs inside a frame and wraps on every tick.
    if (state_reg != IDLE) begin
      div_cnt_next = tick ? '0 : div_cnt_reg + 8'd1;
    end

    case (state_reg)
      IDLE: begin
        div_cnt_next = '0;
        if (accept) begin
          tx_shreg_next = tx_data;
          cs_n_next     = 1'b0;
          bit_cnt_next  = '0;
          ready_next    = 1'b0;
          state_next    = LOW;
        end
      end
      LOW: begin
        if (tick) begin
          sck_next      = 1'b1;
          rx_shreg_next = {rx_shreg_reg[WORD_W-2:0], sdi};
          state_next    = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          sck_next = 1'b0;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = TRAIL;
          end else begin
            bit_cnt_next  = bit_cnt_reg + BIT_W'(1);
            tx_shreg_next = {tx_shreg_reg[WORD_W-2:0], 1'b0};
            state_next    = LOW;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          cs_n_next     = 1'b1;
          rx_data_next  = rx_shreg_reg;
          done_next     = 1'b1;
          ready_next    = 1'b1;
          tx_shreg_next = '0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomised bench for spi_master: two instances (CLK_DIV=4 with slave model, CLK_DIV=1 loopback).
`timescale 1ns/1ps
module tb_spi_master;
  localparam int W    = 32;
  localparam int DIV  = 4;
  localparam int LAT  = (2 * W + 1) * DIV;
  localparam int LAT1 = (2 * W + 1) * 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start, sdi, loop;
  logic [W-1:0] tx_data, rx_data;
  logic         ready, done, sck, sdo, cs_n;
  logic         start1, sdi1;
  logic [W-1:0] tx1, rx1;
  logic         ready1, done1, sck1, sdo1, cs_n1;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] slave_word = '0;
  logic         slave_bit = 1'b0;
  assign sdi  = loop ? sdo : slave_bit;
  assign sdi1 = sdo1;

  spi_master #(.CLK_DIV(DIV), .WORD_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .ready(ready),
    .done(done), .rx_data(rx_data), .sck(sck), .sdo(sdo), .sdi(sdi), .cs_n(cs_n)
  );

  spi_master #(.CLK_DIV(1), .WORD_W(W)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .tx_data(tx1), .ready(ready1),
    .done(done1), .rx_data(rx1), .sck(sck1), .sdo(sdo1), .sdi(sdi1), .cs_n(cs_n1)
  );

  // Bus observer / slave model for the CLK_DIV=4 instance.
  logic sck_q = 1'b0, cs_q = 1'b1, sdo_q = 1'b0;
  logic [W-1:0] cap = '0;
  int cyc = 0, rises = 0, idle_toggles = 0, sdo_unstable = 0, bad_period = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, cs_high_last = 0, last_rise = 0, first_rise = 0;
  int done_cyc = 0, done_count = 0, frames = 0, sidx = 0;

  always @(negedge clk) begin
    cyc++;
    if (cs_n && cs_q && (sck !== sck_q)) idle_toggles++;
    if (!cs_n && cs_q) begin
      frames++;
      cs_fall_cyc  = cyc;
      cs_high_last = cyc - cs_rise_cyc;
      rises = 0;
      cap = '0;
      sidx = W - 1;
      slave_bit = slave_word[W-1];
    end
    if (cs_n && !cs_q) cs_rise_cyc = cyc;
    if (sck && !sck_q) begin
      rises++;
      cap = {cap[W-2:0], sdo};
      if (sdo !== sdo_q) sdo_unstable++;
      if (rises == 1) first_rise = cyc - cs_fall_cyc;
      else if (cyc - last_rise != 2 * DIV) bad_period++;
      last_rise = cyc;
    end
    if (!sck && sck_q) begin
      sidx--;
      if (sidx >= 0) slave_bit = slave_word[sidx];
    end
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    sck_q = sck;
    cs_q  = cs_n;
    sdo_q = sdo;
  end

  // Observer for the CLK_DIV=1 instance.
  logic sck1_q = 1'b0, cs1_q = 1'b1;
  int cyc1 = 0, rises1 = 0, bad_period1 = 0, idle_toggles1 = 0;
  int cs_fall1 = 0, last_rise1 = 0, done_cyc1 = 0;

  always @(negedge clk) begin
    cyc1++;
    if (cs_n1 && cs1_q && (sck1 !== sck1_q)) idle_toggles1++;
    if (!cs_n1 && cs1_q) begin
      cs_fall1 = cyc1;
      rises1 = 0;
    end
    if (sck1 && !sck1_q) begin
      rises1++;
      if (rises1 > 1 && cyc1 - last_rise1 != 2) bad_period1++;
      last_rise1 = cyc1;
    end
    if (done1 === 1'b1) done_cyc1 = cyc1;
    sck1_q = sck1;
    cs1_q  = cs_n1;
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_frame(input logic [W-1:0] word, output bit ok);
    @(negedge clk);
    tx_data = word;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tx_data = $urandom;
    wait_done(ok);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start1 = 1'b0; tx_data = '0; tx1 = '0; loop = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_toggles = 0; idle_toggles1 = 0;
    repeat (50) @(negedge clk);
    #1;
    vectors++; if (sck !== 1'b0) begin miscompares++; $display("FAIL reset_sck: got %b expected 0", sck); end
    vectors++; if (cs_n !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (rx_data !== '0) begin miscompares++; $display("FAIL reset_rx: got %h expected 0", rx_data); end
    vectors++; if (sdo !== 1'b0) begin miscompares++; $display("FAIL reset_sdo: got %b expected 0", sdo); end
    vectors++; if (idle_toggles + idle_toggles1 != 0) begin miscompares++; $display("FAIL reset_idle_sck: got %0d edges expected 0", idle_toggles + idle_toggles1); end
    vectors++; if (ready1 !== 1'b1 || cs_n1 !== 1'b1) begin miscompares++; $display("FAIL reset_div1: got ready=%b cs_n=%b expected 1/1", ready1, cs_n1); end
  endtask

  task automatic test_loopback();
    logic [W-1:0] word;
    bit ok;
    word = 32'hA5C3_0F96;
    loop = 1'b1;
    bad_period = 0; sdo_unstable = 0;
    run_frame(word, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL loop_timeout: got no done expected done"); end
    vectors++; if (rises != W) begin miscompares++; $display("FAIL loop_rises: got %0d expected %0d", rises, W); end
    vectors++; if (cap !== word) begin miscompares++; $display("FAIL loop_sdo_bits: got %h expected %h", cap, word); end
    vectors++; if (done_cyc - cs_fall_cyc != LAT) begin miscompares++; $display("FAIL loop_latency: got %0d expected %0d", done_cyc - cs_fall_cyc, LAT); end
    vectors++; if (rx_data !== word) begin miscompares++; $display("FAIL loop_rx: got %h expected %h", rx_data, word); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL loop_ready: got %b expected 1", ready); end
    vectors++; if (first_rise != DIV) begin miscompares++; $display("FAIL loop_first_rise: got %0d expected %0d", first_rise, DIV); end
    vectors++; if (bad_period != 0) begin miscompares++; $display("FAIL loop_period: got %0d bad periods expected 0", bad_period); end
    @(negedge clk); #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL loop_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_slave(input logic [W-1:0] word, input logic [W-1:0] reply, input string tag);
    bit ok;
    loop = 1'b0;
    slave_word = reply;
    sdo_unstable = 0;
    run_frame(word, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL %s_timeout: got no done expected done", tag); end
    vectors++; if (cap !== word) begin miscompares++; $display("FAIL %s_slave_rx: got %h expected %h", tag, cap, word); end
    vectors++; if (rx_data !== reply) begin miscompares++; $display("FAIL %s_master_rx: got %h expected %h", tag, rx_data, reply); end
    vectors++; if (sdo_unstable != 0) begin miscompares++; $display("FAIL %s_sdo_stable: got %0d changes at sck rise expected 0", tag, sdo_unstable); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int f0, d0;
    loop = 1'b1;
    f0 = frames; d0 = done_count;
    @(negedge clk);
    tx_data = 32'hFFFF_0000;
    start = 1'b1;
    wait_done(ok);
    vectors++; if (!ok || rx_data !== 32'hFFFF_0000) begin miscompares++; $display("FAIL b2b_first_rx: got %h expected ffff0000", rx_data); end
    tx_data = 32'h0000_FFFF;
    wait_done(ok);
    start = 1'b0;
    vectors++; if (!ok || rx_data !== 32'h0000_FFFF) begin miscompares++; $display("FAIL b2b_second_rx: got %h expected 0000ffff", rx_data); end
    vectors++; if (cs_high_last != 1) begin miscompares++; $display("FAIL b2b_cs_high: got %0d cycles expected 1", cs_high_last); end
    vectors++; if (done_cyc - cs_fall_cyc != LAT) begin miscompares++; $display("FAIL b2b_latency: got %0d expected %0d", done_cyc - cs_fall_cyc, LAT); end
    repeat (40) @(negedge clk);
    #1;
    vectors++; if (frames - f0 != 2) begin miscompares++; $display("FAIL b2b_frames: got %0d expected 2", frames - f0); end
    vectors++; if (done_count - d0 != 2) begin miscompares++; $display("FAIL b2b_dones: got %0d expected 2", done_count - d0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    loop = 1'b1;
    @(negedge clk);
    tx_data = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (rises >= 17) break;
    end
    vectors++; if (rises < 17) begin miscompares++; $display("FAIL midrst_reach: got %0d rises expected 17", rises); end
    d0 = done_count;
    reset = 1'b1;
    #1;
    vectors++; if (sck !== 1'b0 || cs_n !== 1'b1) begin miscompares++; $display("FAIL midrst_async: got sck=%b cs_n=%b expected 0/1", sck, cs_n); end
    vectors++; if (rx_data !== '0 || ready !== 1'b1) begin miscompares++; $display("FAIL midrst_state: got rx=%h ready=%b expected 0/1", rx_data, ready); end
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    vectors++; if (done_count != d0) begin miscompares++; $display("FAIL midrst_no_done: got %0d dones expected 0", done_count - d0); end
    run_frame(32'hDEAD_BEEF, ok);
    vectors++; if (!ok || rx_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL midrst_next_rx: got %h expected deadbeef", rx_data); end
    vectors++; if (rises != W) begin miscompares++; $display("FAIL midrst_next_rises: got %0d expected %0d", rises, W); end
  endtask

  task automatic test_clkdiv1(input logic [W-1:0] word, input string tag);
    bit ok;
    bad_period1 = 0;
    @(negedge clk);
    tx1 = word;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    tx1 = $urandom;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (done1 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL %s_timeout: got no done expected done", tag); end
    vectors++; if (done_cyc1 - cs_fall1 != LAT1) begin miscompares++; $display("FAIL %s_latency: got %0d expected %0d", tag, done_cyc1 - cs_fall1, LAT1); end
    vectors++; if (rx1 !== word) begin miscompares++; $display("FAIL %s_rx: got %h expected %h", tag, rx1, word); end
    vectors++; if (rises1 != W || bad_period1 != 0) begin miscompares++; $display("FAIL %s_sck: got %0d rises %0d bad periods expected %0d/0", tag, rises1, bad_period1, W); end
  endtask

  task automatic test_random();
    logic [W-1:0] word, reply;
    for (int n = 0; n < 4; n++) begin
      word = $urandom;
      reply = $urandom;
      test_slave(word, reply, $sformatf("rand%0d", n));
    end
    for (int n = 0; n < 2; n++) begin
      word = $urandom;
      test_clkdiv1(word, $sformatf("rand_div1_%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave(32'h1234_5678, 32'h0000_03FF, "slave");
    test_back_to_back();
    test_reset_mid();
    test_clkdiv1(32'h8000_0001, "div1");
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
